// File: rtl/fsm_job_arb_pkg.sv
// fsm_job_arb_pkg: shared state and outcome types for the job arbiter
package fsm_job_arb_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} arb_state_e;
  typedef enum logic {OUT_DONE, OUT_ERR} arb_outcome_e;
endpackage

// File: rtl/fsm_job_arbiter_if.sv
// fsm_job_arbiter_if: requester and worker signals of the job arbiter
interface fsm_job_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ERR_CNT_W = 8
);
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   gnt_o;
  logic [NUM_REQ-1:0]   done_o;
  logic [NUM_REQ-1:0]   err_o;
  logic                 busy_o;
  logic                 worker_start_o;
  logic                 worker_busy_i;
  logic                 worker_done_i;
  logic [ERR_CNT_W-1:0] err_cnt_o;
  modport slave (
    input  req_i, worker_busy_i, worker_done_i,
    output gnt_o, done_o, err_o, busy_o, worker_start_o, err_cnt_o
  );
  modport master (
    output req_i, worker_busy_i, worker_done_i,
    input  gnt_o, done_o, err_o, busy_o, worker_start_o, err_cnt_o
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or above ptr, wrapping around
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  // Scan furthest offset first so the nearest set bit wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = $clog2(N)'((int'(ptr) + i) % N);
  end
  assign valid = |req;
endmodule

// File: rtl/fsm_job_arbiter.sv
// fsm_job_arbiter: round-robin sequencer sharing one start/busy/done worker
module fsm_job_arbiter
  import fsm_job_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERR_CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fsm_job_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e           r_state, w_next;
  arb_outcome_e         r_out;
  logic [IW-1:0]        r_idx, r_ptr, w_pick;
  logic [CW-1:0]        r_cnt;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_valid, w_timeout;
  logic [NUM_REQ-1:0]   w_onehot;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (bus.req_i),
    .ptr  (r_ptr),
    .valid(w_valid),
    .idx  (w_pick)
  );

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
  assign w_next = (r_state == IDLE)  ? (w_valid ? START : IDLE) :
                  (r_state == START) ? WAIT :
                  (r_state == WAIT)  ? ((bus.worker_done_i || w_timeout) ? RELEASE : WAIT) :
                  IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_out     <= OUT_DONE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && w_valid) r_idx <= w_pick;
      // Done outranks a simultaneous timeout
      if (r_state == WAIT) r_out <= bus.worker_done_i ? OUT_DONE : OUT_ERR;
      if (r_state == RELEASE) begin
        r_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        if (r_out == OUT_ERR && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign w_onehot           = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
  assign bus.gnt_o          = (r_state == START || r_state == WAIT) ? w_onehot : '0;
  assign bus.done_o         = (r_state == RELEASE && r_out == OUT_DONE) ? w_onehot : '0;
  assign bus.err_o          = (r_state == RELEASE && r_out == OUT_ERR) ? w_onehot : '0;
  assign bus.busy_o         = r_state != IDLE;
  assign bus.worker_start_o = r_state == START;
  assign bus.err_cnt_o      = r_err_cnt;
endmodule

// File: tb/tb_fsm_job_arbiter.sv
// tb_fsm_job_arbiter: directed scenarios against a behavioural shared worker
module tb_fsm_job_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_job_arbiter_if #(.NUM_REQ(4), .ERR_CNT_W(8)) bus ();
  fsm_job_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8), .ERR_CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic wk_busy, wk_done, f_done, wk_en;
  int   wk_delay, wk_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign bus.worker_busy_i = wk_busy;
  assign bus.worker_done_i = wk_done | f_done;

  // Worker: done pulses wk_delay+1 cycles after the start cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wk_busy <= 1'b0;
      wk_done <= 1'b0;
      wk_cnt  <= 0;
    end else begin
      wk_done <= 1'b0;
      if (bus.worker_start_o) begin
        wk_busy <= 1'b1;
        wk_cnt  <= wk_delay;
      end else if (wk_busy) begin
        if (wk_cnt == 1) begin
          wk_busy <= 1'b0;
          wk_done <= wk_en;
        end else wk_cnt <= wk_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (bus.gnt_o == 4'b0 && cyc < 20) begin
      tick();
      cyc++;
    end
    if (bus.gnt_o == 4'b0) cyc = -1;
  endtask

  task automatic wait_outcome(output int cyc, output int starts);
    cyc = 0;
    starts = 0;
    do begin
      tick();
      cyc++;
      if (bus.worker_start_o) starts++;
    end while ((bus.done_o | bus.err_o) == 4'b0 && cyc < 100);
    if ((bus.done_o | bus.err_o) == 4'b0) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 4'b0;
    f_done = 1'b0;
    wk_en = 1'b1;
    wk_delay = 5;
    #12;
    n_cmp++;
    if ({bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.worker_start_o, bus.err_cnt_o} !== 22'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b busy=%b start=%b cnt=%0d want all 0",
               bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.worker_start_o, bus.err_cnt_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int c, s;
    bus.req_i = 4'b0001;
    tick();
    n_cmp++;
    if ({bus.gnt_o, bus.worker_start_o, bus.busy_o} !== 6'b0001_1_1) begin
      n_bad++;
      $display("FAIL single_start: got gnt=%b start=%b busy=%b want 0001 1 1", bus.gnt_o, bus.worker_start_o, bus.busy_o);
    end
    tick();
    n_cmp++;
    if ({bus.gnt_o, bus.worker_start_o} !== 5'b0001_0) begin
      n_bad++;
      $display("FAIL single_wait: got gnt=%b start=%b want 0001 0", bus.gnt_o, bus.worker_start_o);
    end
    wait_outcome(c, s);
    n_cmp++;
    if (c != 6 || bus.done_o !== 4'b0001 || bus.err_o !== 4'b0 || s != 0) begin
      n_bad++;
      $display("FAIL single_done: got cyc=%0d done=%b err=%b starts=%0d want 6 0001 0000 0", c, bus.done_o, bus.err_o, s);
    end
    bus.req_i = 4'b0;
    tick();
    n_cmp++;
    if ({bus.gnt_o, bus.done_o, bus.busy_o} !== 9'b0) begin
      n_bad++;
      $display("FAIL single_idle: got gnt=%b done=%b busy=%b want 0", bus.gnt_o, bus.done_o, bus.busy_o);
    end
  endtask

  task automatic test_contention();
    int c, s;
    logic [3:0] g, w;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      w = 4'b0001 << (j % 4);
      wait_gnt(c);
      g = bus.gnt_o;
      n_cmp++;
      if (c < 0 || g !== w) begin
        n_bad++;
        $display("FAIL contention_gnt%0d: got gnt=%b want %b", j, g, w);
      end
      wait_outcome(c, s);
      n_cmp++;
      if (c < 0 || bus.done_o !== w || bus.err_o !== 4'b0 || s != 0) begin
        n_bad++;
        $display("FAIL contention_done%0d: got done=%b err=%b starts=%0d want %b 0000 0", j, bus.done_o, bus.err_o, s, w);
      end
    end
    bus.req_i = 4'b0;
    tick();
  endtask

  task automatic test_timeout();
    int c, s;
    wk_en = 1'b0;
    bus.req_i = 4'b0100;
    wait_gnt(c);
    n_cmp++;
    if (bus.gnt_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL timeout_gnt: got gnt=%b want 0100", bus.gnt_o);
    end
    wait_outcome(c, s);
    n_cmp++;
    if (c != 9 || bus.err_o !== 4'b0100 || bus.done_o !== 4'b0 || bus.err_cnt_o !== 8'd0) begin
      n_bad++;
      $display("FAIL timeout_err: got cyc=%0d err=%b done=%b cnt=%0d want 9 0100 0000 0", c, bus.err_o, bus.done_o, bus.err_cnt_o);
    end
    bus.req_i = 4'b0;
    tick();
    n_cmp++;
    if (bus.err_cnt_o !== 8'd1 || bus.err_o !== 4'b0) begin
      n_bad++;
      $display("FAIL timeout_cnt: got cnt=%0d err=%b want 1 0000", bus.err_cnt_o, bus.err_o);
    end
    wk_en = 1'b1;
  endtask

  task automatic test_coincident();
    int c, s;
    wk_delay = 7;
    bus.req_i = 4'b0010;
    wait_gnt(c);
    n_cmp++;
    if (bus.gnt_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL coinc_gnt: got gnt=%b want 0010", bus.gnt_o);
    end
    wait_outcome(c, s);
    n_cmp++;
    if (c != 9 || bus.done_o !== 4'b0010 || bus.err_o !== 4'b0) begin
      n_bad++;
      $display("FAIL coinc_done: got cyc=%0d done=%b err=%b want 9 0010 0000", c, bus.done_o, bus.err_o);
    end
    bus.req_i = 4'b0;
    tick();
    n_cmp++;
    if (bus.err_cnt_o !== 8'd1) begin
      n_bad++;
      $display("FAIL coinc_cnt: got cnt=%0d want 1", bus.err_cnt_o);
    end
    wk_delay = 5;
  endtask

  task automatic test_reset_mid();
    int c, s;
    bus.req_i = 4'b0001;
    wait_gnt(c);
    n_cmp++;
    if (bus.gnt_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL rmid_gnt: got gnt=%b want 0001", bus.gnt_o);
    end
    tick();
    tick();
    rst_n = 1'b0;
    bus.req_i = 4'b0;
    #1;
    n_cmp++;
    if ({bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.worker_start_o, bus.err_cnt_o} !== 22'b0) begin
      n_bad++;
      $display("FAIL rmid_async: got gnt=%b busy=%b cnt=%0d want 0", bus.gnt_o, bus.busy_o, bus.err_cnt_o);
    end
    tick();
    tick();
    n_cmp++;
    if ({bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o} !== 13'b0) begin
      n_bad++;
      $display("FAIL rmid_hold: got gnt=%b done=%b err=%b busy=%b want 0", bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o);
    end
    rst_n = 1'b1;
    bus.req_i = 4'b0101;
    wait_gnt(c);
    n_cmp++;
    if (bus.gnt_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL rmid_ptr: got gnt=%b want 0001", bus.gnt_o);
    end
    bus.req_i = 4'b0;
    wait_outcome(c, s);
    n_cmp++;
    if (bus.done_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL rmid_done: got done=%b want 0001", bus.done_o);
    end
    tick();
  endtask

  task automatic test_spurious();
    int c, s, extra;
    f_done = 1'b1;
    tick();
    n_cmp++;
    if ({bus.busy_o, bus.done_o, bus.err_o, bus.gnt_o} !== 13'b0) begin
      n_bad++;
      $display("FAIL spur_idle: got busy=%b done=%b err=%b gnt=%b want 0", bus.busy_o, bus.done_o, bus.err_o, bus.gnt_o);
    end
    f_done = 1'b0;
    bus.req_i = 4'b1000;
    tick();
    n_cmp++;
    if ({bus.gnt_o, bus.worker_start_o} !== 5'b1000_1) begin
      n_bad++;
      $display("FAIL spur_start: got gnt=%b start=%b want 1000 1", bus.gnt_o, bus.worker_start_o);
    end
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    n_cmp++;
    if ({bus.gnt_o, bus.worker_start_o, bus.done_o} !== 9'b1000_0_0000) begin
      n_bad++;
      $display("FAIL spur_wait: got gnt=%b start=%b done=%b want 1000 0 0000", bus.gnt_o, bus.worker_start_o, bus.done_o);
    end
    bus.req_i = 4'b0;
    wait_outcome(c, s);
    n_cmp++;
    if (c != 6 || bus.done_o !== 4'b1000 || bus.err_o !== 4'b0) begin
      n_bad++;
      $display("FAIL spur_done: got cyc=%0d done=%b err=%b want 6 1000 0000", c, bus.done_o, bus.err_o);
    end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ((bus.done_o | bus.err_o | bus.gnt_o) != 4'b0) extra++;
    end
    n_cmp++;
    if (extra != 0 || bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_after: got extra=%0d busy=%b want 0 0", extra, bus.busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_coincident();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsm_job_arbiter.md
Name: fsm_job_arbiter

Overview:
Round-robin arbiter and sequencer that shares one start/busy/done worker (fsm_example, WAIT_CYCLES-parameterised) among NUM_REQ requesters. It grants one requester at a time and issues a single-cycle start to the worker. It then waits for the worker's done, routes a done pulse back to the granted requester and rotates priority. A watchdog aborts jobs whose done never arrives. The block sits between the requesting clients and the shared worker instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before abort. 0 disables the watchdog.
ERR_CNT_W, 8, width of the saturating timeout counter output.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
req_i  in  NUM_REQ  per-requester job request. Level signal, held until done_o/err_o.
gnt_o  out  NUM_REQ  one-hot grant, high for the whole job (START+WAIT).
done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
err_o  out  NUM_REQ  one-cycle timeout-abort pulse to the granted requester.
busy_o  out  1  arbiter not in IDLE.
worker_start_o  out  1  start pulse to the shared worker.
worker_busy_i  in  1  worker busy; status only, not used for sequencing.
worker_done_i  in  1  worker done.
err_cnt_o  out  ERR_CNT_W  saturating count of timeouts.

Behaviour:
- Reset (async, any time, including mid-job):
  - state=IDLE, rr pointer=0, timeout counter=0, err_cnt_o=0.
  - All outputs 0.
  - A job in progress is dropped with no done/err pulse. The worker shares rst_n.
- FSM states IDLE, START, WAIT, RELEASE. Outputs are Moore-decoded from registered state and grant index.
- IDLE:
  - If req_i != 0, pick the first set bit scanning from the rr pointer upward with wrap-around, register it as idx, and go to START.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle): gnt_o[idx]=1, worker_start_o=1, timeout counter cleared. Next state is WAIT.
- WAIT:
  - gnt_o[idx]=1.
  - If worker_done_i=1: next state RELEASE, outcome=done.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: next state RELEASE, outcome=error.
  - Otherwise counter+1.
  - done and timeout in the same cycle: done wins.
- RELEASE (1 cycle):
  - gnt_o=0.
  - done_o[idx]=1 or err_o[idx]=1 according to the outcome.
  - On error, err_cnt_o increments, saturating at all-ones.
  - rr pointer := (idx+1) mod NUM_REQ. Next state IDLE.
- Latency: req_i sampled high in IDLE at edge k gives gnt_o and worker_start_o in cycle k+1. done_o appears 1 cycle after worker_done_i is sampled. At least 1 IDLE cycle separates consecutive jobs.
- Input handling:
  - worker_done_i outside WAIT is ignored.
  - req_i[idx] dropping mid-job is ignored; the job runs to completion and still pulses done_o/err_o.
  - A requester holding req_i after done_o is re-arbitrated behind the others.
- Fairness: with all requesters asserting continuously, grants cycle 0,1,2,...,NUM_REQ-1,0. There is no starvation.
- Invariants: gnt_o, done_o and err_o are each one-hot or zero. done_o and err_o are never high together.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Package fsm_job_arb_pkg: state enum (IDLE, START, WAIT, RELEASE) and outcome enum (OUT_DONE, OUT_ERR).
- Sub-module rr_pick: combinational round-robin selector (req vector, pointer in; valid, index out), reusable elsewhere.

Test Plan:
- Single requester, worker WAIT_CYCLES=5: req_i=0001 held → gnt_o=0001 the cycle after sampling; exactly one worker_start_o cycle; done_o=0001 one cycle after worker_done_i; then gnt_o=0, busy_o=0.
- Contention: req_i=1111 held for 5 jobs → grant order 0,1,2,3,0. No two gnt_o bits ever high together. Exactly one done_o per job.
- Timeout: TIMEOUT_CYCLES=8 with worker_done_i tied 0 → err_o[idx] pulses 8 cycles after entering WAIT; err_cnt_o 0→1; no done_o.
- Done coincident with last timeout cycle → done_o pulses, err_o stays 0, err_cnt_o unchanged.
- Reset mid-WAIT: rst_n low for 2 cycles → all outputs 0 immediately (async); pointer 0; after release, req_i=0100 grants requester 2.
- Spurious worker_done_i in IDLE/START and req_i dropped mid-job → no effect; job completes with exactly one done_o.
